// File: rtl/yarvi_uart_tx.sv
// UART transmitter: ready/valid byte input, FIFO buffer, 8N1 framing.
// Define YARVI_UART_PARITY_EN to add an even-parity bit (8E1 framing).
module yarvi_uart_tx #(
   parameter int CLK_HZ    = 50000000,
   parameter int BAUD      = 115200,
   parameter int FIFO_LOG2 = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 tx_valid,
   input  logic [7:0]           tx_data,
   output logic                 tx_ready,
   output logic                 serial_out,
   output logic                 busy,
   output logic [FIFO_LOG2:0]   fifo_level
);

   localparam int DIVISOR = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam int DEPTH   = 1 << FIFO_LOG2;
   localparam int LVL_W   = FIFO_LOG2 + 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIVISOR - 1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef YARVI_UART_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

`ifdef YARVI_UART_PARITY_EN
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction
`endif

   state_t                  state_q,  state_d;
   logic [7:0]              mem_q [DEPTH];
   logic [7:0]              mem_d [DEPTH];
   logic [FIFO_LOG2-1:0]    wr_ptr_q, wr_ptr_d;
   logic [FIFO_LOG2-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]        level_q,  level_d;
   logic [7:0]              shift_q,  shift_d;
   logic [CNT_W-1:0]        baud_q,   baud_d;
   logic [2:0]              bit_q,    bit_d;
   logic                    serial_q, serial_d;
`ifdef YARVI_UART_PARITY_EN
   logic                    parity_q, parity_d;
`endif
   logic                    full_s;
   logic                    push_s;
   logic                    pop_s;
   logic                    baud_last_s;
   logic                    fifo_nonempty_s;

   assign full_s          = (level_q == LVL_FULL);
   assign push_s          = tx_valid && !full_s;
   assign baud_last_s     = (baud_q == CNT_W'(0));
   assign fifo_nonempty_s = (level_q != LVL_ZERO);

   assign tx_ready   = !full_s;
   assign serial_out = serial_q;
   assign busy       = (state_q != S_IDLE) || fifo_nonempty_s;
   assign fifo_level = level_q;

   // Frame sequencer: every state but IDLE lasts one baud period; pops load the shifter.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      pop_s    = 1'b0;
`ifdef YARVI_UART_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (fifo_nonempty_s) begin
               pop_s    = 1'b1;
               shift_d  = mem_q[rd_ptr_q];
`ifdef YARVI_UART_PARITY_EN
               parity_d = even_parity(mem_q[rd_ptr_q]);
`endif
               baud_d   = CNT_MAX;
               state_d  = S_START;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_START: begin
            if (baud_last_s) begin
               baud_d  = CNT_MAX;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               baud_d  = baud_q - CNT_W'(1);
            end
         end
         S_DATA: begin
            if (baud_last_s) begin
               baud_d  = CNT_MAX;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
`ifdef YARVI_UART_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d  = baud_q - CNT_W'(1);
            end
         end
`ifdef YARVI_UART_PARITY_EN
         S_PARITY: begin
            if (baud_last_s) begin
               baud_d  = CNT_MAX;
               state_d = S_STOP;
            end else begin
               baud_d  = baud_q - CNT_W'(1);
            end
         end
`endif
         S_STOP: begin
            // Chain straight into the next start bit when more data is waiting.
            if (baud_last_s) begin
               if (fifo_nonempty_s) begin
                  pop_s    = 1'b1;
                  shift_d  = mem_q[rd_ptr_q];
`ifdef YARVI_UART_PARITY_EN
                  parity_d = even_parity(mem_q[rd_ptr_q]);
`endif
                  baud_d   = CNT_MAX;
                  state_d  = S_START;
               end else begin
                  state_d  = S_IDLE;
               end
            end else begin
               baud_d = baud_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Line level follows the current state, registered so the pin never glitches.
   always_comb begin
      serial_d = 1'b1;
      case (state_q)
         S_START:  serial_d = 1'b0;
         S_DATA:   serial_d = shift_q[0];
`ifdef YARVI_UART_PARITY_EN
         S_PARITY: serial_d = parity_q;
`endif
         default:  serial_d = 1'b1;
      endcase
   end

   // FIFO bookkeeping; push and pop in the same cycle cancel in the level.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_s) begin
         mem_d[wr_ptr_q] = tx_data;
         wr_ptr_d        = wr_ptr_q + FIFO_LOG2'(1);
      end else begin
         wr_ptr_d        = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + FIFO_LOG2'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         shift_q  <= 8'h00;
         baud_q   <= '0;
         bit_q    <= 3'd0;
         serial_q <= 1'b1;
`ifdef YARVI_UART_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         shift_q  <= shift_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         serial_q <= serial_d;
`ifdef YARVI_UART_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

endmodule
